// File: rtl/decode_unit_pkg.sv
// decode_unit_pkg: shared widths, opcodes, NOP encoding and control decode for the decode stage
package decode_unit_pkg;
    localparam int INST_WIDTH      = 32;
    localparam int REG_FILE_WIDTH  = 32;
    localparam int VIRT_ADDR_WIDTH = 32;
    localparam int ADDR_WIDTH      = 5;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_MUL  = 6'h02;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LDW  = 6'h10;
    localparam logic [5:0] OP_STW  = 6'h11;
    localparam logic [5:0] OP_BEQ  = 6'h30;

    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'hFC00_0000;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_MUL = 2'b10
    } alu_op_e;

    typedef struct packed {
        logic    wb_en;
        logic    mem_r_en;
        logic    mem_w_en;
        logic    mem_to_reg;
        logic    alu_reg_dest;
        logic    is_branch;
        logic    is_immediate;
        alu_op_e alu_op;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [5:0] op);
        ctrl_t c;
        c = '0;
        case (op)
            OP_ADD:  begin c.wb_en = 1'b1; c.alu_reg_dest = 1'b1; end
            OP_SUB:  begin c.wb_en = 1'b1; c.alu_reg_dest = 1'b1; c.alu_op = ALU_SUB; end
            OP_MUL:  begin c.wb_en = 1'b1; c.alu_reg_dest = 1'b1; c.alu_op = ALU_MUL; end
            OP_ADDI: begin c.wb_en = 1'b1; c.is_immediate = 1'b1; end
            OP_LDW:  begin c.wb_en = 1'b1; c.is_immediate = 1'b1; c.mem_r_en = 1'b1; c.mem_to_reg = 1'b1; end
            OP_STW:  begin c.is_immediate = 1'b1; c.mem_w_en = 1'b1; end
            OP_BEQ:  begin c.is_branch = 1'b1; c.alu_op = ALU_SUB; end
            default: c = '0;
        endcase
        return c;
    endfunction
endpackage

// File: rtl/decode_unit_decode_ctrl.sv
// decode_ctrl: stall-driven NOP bubble mux, control decode and per-stage register enables
module decode_ctrl
    import decode_unit_pkg::*;
(
    input  logic [INST_WIDTH-1:0] instruction,
    input  logic                  block_icache,
    input  logic                  block_dcache,
    output logic [INST_WIDTH-1:0] inst,
    output ctrl_t                 ctrl,
    output logic                  en_reg_fetch,
    output logic                  en_reg_decode,
    output logic                  en_reg_alu,
    output logic                  en_reg_mem
);
    logic stall;

    assign stall = block_icache | block_dcache;
    assign inst  = stall ? NOP_INST : instruction;
    assign ctrl  = decode_op(inst[31:26]);

    // An icache stall freezes only the front end so the bubble drains downstream
    assign en_reg_fetch  = ~stall;
    assign en_reg_decode = ~stall;
    assign en_reg_alu    = ~block_dcache;
    assign en_reg_mem    = ~block_dcache;
endmodule

// File: rtl/decode_unit_gpr_file.sv
// gpr_file: 32x32 register file, async reads, r0 hardwired to zero, write-first bypass
module gpr_file
    import decode_unit_pkg::*;
(
    input  logic                      clk,
    input  logic [ADDR_WIDTH-1:0]     addr_a,
    input  logic [ADDR_WIDTH-1:0]     addr_b,
    input  logic [ADDR_WIDTH-1:0]     wb_addr,
    input  logic [REG_FILE_WIDTH-1:0] wb_data,
    input  logic                      wb_we,
    output logic [REG_FILE_WIDTH-1:0] data_a,
    output logic [REG_FILE_WIDTH-1:0] data_b
);
    logic [REG_FILE_WIDTH-1:0] mem [32];

    always_ff @(posedge clk)
        if (wb_we && wb_addr != '0) mem[wb_addr] <= wb_data;

    // Bypass lets a same-cycle write-back feed the operand being decoded
    assign data_a = (addr_a == '0) ? '0 : (wb_we && wb_addr == addr_a) ? wb_data : mem[addr_a];
    assign data_b = (addr_b == '0) ? '0 : (wb_we && wb_addr == addr_b) ? wb_data : mem[addr_b];
endmodule

// File: rtl/decode_unit.sv
// decode_unit: decode stage top, holds the decode->ALU pipeline register
module decode_unit
    import decode_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic [VIRT_ADDR_WIDTH-1:0] pc_in,
    input  logic [INST_WIDTH-1:0]      instruction,
    input  logic [ADDR_WIDTH-1:0]      wb_addr,
    input  logic [REG_FILE_WIDTH-1:0]  wb_data,
    input  logic                       wb_we,
    input  logic                       wrt_en,
    input  logic                       block_dcache,
    input  logic                       block_icache,
    output logic [REG_FILE_WIDTH-1:0]  data_a,
    output logic [REG_FILE_WIDTH-1:0]  data_b,
    output logic [REG_FILE_WIDTH-1:0]  imm,
    output logic [VIRT_ADDR_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0]      addr_a,
    output logic [ADDR_WIDTH-1:0]      addr_b,
    output logic [ADDR_WIDTH-1:0]      reg_d,
    output logic [ADDR_WIDTH-1:0]      reg_d_imme,
    output logic                       wb_en,
    output logic                       mem_r_en,
    output logic                       mem_w_en,
    output logic                       mem_to_reg,
    output logic                       alu_reg_dest,
    output logic                       is_branch,
    output logic                       is_immediate,
    output logic [1:0]                 alu_op,
    output logic                       en_reg_fetch,
    output logic                       en_reg_decode,
    output logic                       en_reg_alu,
    output logic                       en_reg_mem
);
    logic [INST_WIDTH-1:0]     inst;
    ctrl_t                     ctrl;
    logic [REG_FILE_WIDTH-1:0] rd_a;
    logic [REG_FILE_WIDTH-1:0] rd_b;

    decode_ctrl u_decode_ctrl (
        .instruction  (instruction),
        .block_icache (block_icache),
        .block_dcache (block_dcache),
        .inst         (inst),
        .ctrl         (ctrl),
        .en_reg_fetch (en_reg_fetch),
        .en_reg_decode(en_reg_decode),
        .en_reg_alu   (en_reg_alu),
        .en_reg_mem   (en_reg_mem)
    );

    gpr_file u_gpr_file (
        .clk    (clk),
        .addr_a (inst[25:21]),
        .addr_b (inst[20:16]),
        .wb_addr(wb_addr),
        .wb_data(wb_data),
        .wb_we  (wb_we),
        .data_a (rd_a),
        .data_b (rd_b)
    );

    always_ff @(posedge clk)
        if (reset) begin
            data_a       <= '0;
            data_b       <= '0;
            imm          <= '0;
            pc_out       <= '0;
            addr_a       <= '0;
            addr_b       <= '0;
            reg_d        <= '0;
            reg_d_imme   <= '0;
            wb_en        <= 1'b0;
            mem_r_en     <= 1'b0;
            mem_w_en     <= 1'b0;
            mem_to_reg   <= 1'b0;
            alu_reg_dest <= 1'b0;
            is_branch    <= 1'b0;
            is_immediate <= 1'b0;
            alu_op       <= '0;
        end else if (wrt_en) begin
            data_a       <= rd_a;
            data_b       <= rd_b;
            imm          <= {16'h0, inst[15:0]};
            pc_out       <= pc_in;
            addr_a       <= inst[25:21];
            addr_b       <= inst[20:16];
            reg_d        <= inst[20:16];
            reg_d_imme   <= inst[15:11];
            wb_en        <= ctrl.wb_en;
            mem_r_en     <= ctrl.mem_r_en;
            mem_w_en     <= ctrl.mem_w_en;
            mem_to_reg   <= ctrl.mem_to_reg;
            alu_reg_dest <= ctrl.alu_reg_dest;
            is_branch    <= ctrl.is_branch;
            is_immediate <= ctrl.is_immediate;
            alu_op       <= ctrl.alu_op;
        end
endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit: directed test-plan vectors plus randomized traffic against a behavioural model
module tb_decode_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, instruction, wb_data;
    logic [4:0]  wb_addr;
    logic        wb_we, wrt_en, block_dcache, block_icache;
    logic [31:0] data_a, data_b, imm, pc_out;
    logic [4:0]  addr_a, addr_b, reg_d, reg_d_imme;
    logic        wb_en, mem_r_en, mem_w_en, mem_to_reg, alu_reg_dest, is_branch, is_immediate;
    logic [1:0]  alu_op;
    logic        en_reg_fetch, en_reg_decode, en_reg_alu, en_reg_mem;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_regs [32];
    logic [31:0] e_da, e_db, e_imm, e_pc;
    logic [4:0]  e_aa, e_ab, e_rd, e_rdi;
    logic [8:0]  e_ctl;

    always #5 clk = ~clk;

    decode_unit dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .instruction(instruction),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_we(wb_we), .wrt_en(wrt_en),
        .block_dcache(block_dcache), .block_icache(block_icache),
        .data_a(data_a), .data_b(data_b), .imm(imm), .pc_out(pc_out),
        .addr_a(addr_a), .addr_b(addr_b), .reg_d(reg_d), .reg_d_imme(reg_d_imme),
        .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_to_reg(mem_to_reg),
        .alu_reg_dest(alu_reg_dest), .is_branch(is_branch), .is_immediate(is_immediate),
        .alu_op(alu_op), .en_reg_fetch(en_reg_fetch), .en_reg_decode(en_reg_decode),
        .en_reg_alu(en_reg_alu), .en_reg_mem(en_reg_mem)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {wb_en, mem_r_en, mem_w_en, mem_to_reg, alu_reg_dest, is_branch, is_immediate, alu_op[1:0]}
    function automatic logic [8:0] ref_ctl(input logic [5:0] op);
        if (op == 6'h00) return 9'b1000_1000_0 | 9'b0;
        if (op == 6'h01) return 9'b100010001;
        if (op == 6'h02) return 9'b100010010;
        if (op == 6'h08) return 9'b100000100;
        if (op == 6'h10) return 9'b110100100;
        if (op == 6'h11) return 9'b001000100;
        if (op == 6'h30) return 9'b000001001;
        return 9'b0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [4:0] a, input logic [4:0] wa,
                                           input logic [31:0] wd, input logic we);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [15:0] i16);
        return {op, a, b, i16};
    endfunction

    task automatic cyc(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] wa,
                       input logic [31:0] wd, input logic wwe, input logic wen,
                       input logic bi, input logic bd, input logic rs);
        logic [31:0] i;
        instruction = ins; pc_in = pc; wb_addr = wa; wb_data = wd; wb_we = wwe;
        wrt_en = wen; block_icache = bi; block_dcache = bd; reset = rs;
        #1;
        check("en_fetch",  {31'h0, en_reg_fetch},  {31'h0, !(bi || bd)});
        check("en_decode", {31'h0, en_reg_decode}, {31'h0, !(bi || bd)});
        check("en_alu",    {31'h0, en_reg_alu},    {31'h0, !bd});
        check("en_mem",    {31'h0, en_reg_mem},    {31'h0, !bd});
        i = (bi || bd) ? 32'hFC00_0000 : ins;
        if (rs) begin
            e_da = 0; e_db = 0; e_imm = 0; e_pc = 0;
            e_aa = 0; e_ab = 0; e_rd = 0; e_rdi = 0; e_ctl = 0;
        end else if (wen) begin
            e_da  = ref_rd(i[25:21], wa, wd, wwe);
            e_db  = ref_rd(i[20:16], wa, wd, wwe);
            e_imm = {16'h0, i[15:0]};
            e_pc  = pc;
            e_aa  = i[25:21]; e_ab = i[20:16]; e_rd = i[20:16]; e_rdi = i[15:11];
            e_ctl = ref_ctl(i[31:26]);
        end
        @(posedge clk);
        if (wwe && wa != 0) m_regs[wa] = wd;
        #1;
        check("data_a", data_a, e_da);
        check("data_b", data_b, e_db);
        check("imm", imm, e_imm);
        check("pc_out", pc_out, e_pc);
        check("addrs", {12'h0, addr_a, addr_b, reg_d, reg_d_imme}, {12'h0, e_aa, e_ab, e_rd, e_rdi});
        check("ctrl", {23'h0, wb_en, mem_r_en, mem_w_en, mem_to_reg, alu_reg_dest,
                       is_branch, is_immediate, alu_op}, {23'h0, e_ctl});
    endtask

    initial begin
        logic [5:0] ops [8];
        logic [5:0] op;
        logic [4:0] wa;
        logic [31:0] ins;
        ops = '{6'h00, 6'h01, 6'h02, 6'h08, 6'h10, 6'h11, 6'h30, 6'h3F};
        for (int k = 0; k < 32; k++) m_regs[k] = 32'h0;
        {reset, pc_in, instruction, wb_addr, wb_data, wb_we, wrt_en, block_dcache, block_icache} = '0;
        @(posedge clk); #1;
        cyc(mk(6'h00, 3, 4, 16'h1234), 32'h100, 0, 0, 0, 1, 0, 0, 1);
        for (int k = 0; k < 32; k++) cyc(32'hFC00_0000, 0, 5'(k), $urandom, 1, 0, 0, 0, 0);
        cyc(32'hFC00_0000, 0, 5, 32'h1234_5678, 1, 0, 0, 0, 0);
        cyc(mk(6'h00, 5, 6, 16'h3800), 32'h200, 0, 0, 0, 1, 0, 0, 0);
        check("plan_add_a", data_a, 32'h1234_5678);
        check("plan_add_rdi", {27'h0, reg_d_imme}, 32'd7);
        check("plan_add_ctl", {23'h0, wb_en, alu_reg_dest, alu_op, mem_r_en, is_immediate, 3'b0}, {23'h0, 6'b110000, 3'b0});
        cyc(mk(6'h10, 1, 2, 16'hFFFF), 32'h204, 0, 0, 0, 1, 0, 0, 0);
        check("plan_ldw_imm", imm, 32'h0000_FFFF);
        check("plan_ldw_ctl", {28'h0, mem_r_en, mem_to_reg, wb_en, is_immediate}, 32'hF);
        cyc(mk(6'h00, 5, 6, 16'h3800), 32'h208, 0, 0, 0, 1, 1, 0, 0);
        check("plan_bubble", {25'h0, wb_en, mem_r_en, mem_w_en, mem_to_reg, alu_reg_dest, is_branch, is_immediate}, 32'h0);
        cyc(mk(6'h01, 5, 6, 16'h3800), 32'h20C, 0, 0, 0, 1, 0, 1, 0);
        cyc(mk(6'h00, 5, 6, 16'h3800), 32'h210, 0, 0, 0, 1, 1, 1, 0);
        cyc(32'hFC00_0000, 0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
        cyc(mk(6'h00, 0, 5, 16'h0), 32'h214, 0, 0, 0, 1, 0, 0, 0);
        check("plan_r0", data_a, 32'h0);
        cyc(mk(6'h02, 9, 0, 16'h0800), 32'h218, 9, 32'hCAFE_BABE, 1, 1, 0, 0, 0);
        check("plan_bypass", data_a, 32'hCAFE_BABE);
        cyc(mk(6'h30, 1, 2, 16'h0), 32'h21C, 0, 0, 0, 0, 0, 0, 0);
        cyc(mk(6'h11, 3, 4, 16'h5555), 32'h220, 0, 0, 0, 0, 0, 0, 0);
        check("plan_hold_pc", pc_out, 32'h218);
        cyc(mk(6'h08, 3, 4, 16'h5555), 32'h224, 7, 32'h77, 1, 1, 0, 0, 1);
        check("plan_reset", {data_a[15:0], imm[15:0]}, 32'h0);
        for (int n = 0; n < 600; n++) begin
            op  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : ops[$urandom_range(0, 7)];
            ins = mk(op, 5'($urandom), 5'($urandom), 16'($urandom));
            wa  = ($urandom_range(0, 2) == 0) ? ins[25:21] : 5'($urandom);
            cyc(ins, $urandom, wa, $urandom, 1'($urandom), $urandom_range(0, 3) != 0,
                $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 40) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
